maze_player_ctrl: RTL and testbench



---
 rtl/maze_player_ctrl_pkg.sv | 40 ++++
 rtl/maze_player_ctrl_if.sv | 32 +++
 rtl/maze_player_ctrl.sv | 144 ++++++++++++++
 tb/tb_maze_player_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/maze_player_ctrl_pkg.sv
// Shared maze constants, FSM/direction encodings and the direction priority helper.
// The map ROM and the renderer use the same constants.
package maze_pkg;

    localparam int COLS    = 30;
    localparam int ROWS    = 20;
    localparam int CELL_PX = 16;

    localparam int CELL_W  = 5;
    localparam int ADDR_W  = 5;
    localparam int PIX_W   = 10;
    localparam int CNT_W   = 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_WIN   = 2'd3
    } maze_state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Priority up > down > left > right; DIR_RIGHT is also returned when no pulse is set.
    function automatic dir_e pick_dir(input logic up, input logic down,
                                      input logic left, input logic right);
        dir_e d;
        if (up)         d = DIR_UP;
        else if (down)  d = DIR_DOWN;
        else if (left)  d = DIR_LEFT;
        else if (right) d = DIR_RIGHT;
        else            d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/maze_player_ctrl_if.sv
// Bundle between the player controller and its surroundings: button pulses, map ROM port,
// renderer/status outputs and the FSM state for observation.
// The pulses are one-cycle strobes with no handshake; a pulse not taken in the cycle it is
// high is lost. map_row answers map_addr one clock later.
interface maze_player_ctrl_if;
    import maze_pkg::*;

    logic                up_p;
    logic                down_p;
    logic                left_p;
    logic                right_p;
    logic                centre_p;
    logic [ADDR_W-1:0]   map_addr;
    logic [COLS-1:0]     map_row;
    logic [PIX_W-1:0]    x_coord;
    logic [PIX_W-1:0]    y_coord;
    logic [CNT_W-1:0]    move_count;
    logic                win;
    logic                busy;
    maze_state_e         state;

    modport master (
        input  up_p, down_p, left_p, right_p, centre_p, map_row,
        output map_addr, x_coord, y_coord, move_count, win, busy, state
    );

    modport slave (
        output up_p, down_p, left_p, right_p, centre_p, map_row,
        input  map_addr, x_coord, y_coord, move_count, win, busy, state
    );

endinterface

// File: rtl/maze_player_ctrl.sv
// Player movement controller: decodes direction pulses, checks the target cell against the
// external map ROM and commits legal moves, tracking the move count and the win condition.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int GOAL_X    = 29,
    parameter int GOAL_Y    = 19,
    parameter int MAX_MOVES = 9999
) (
    input  logic                 Clk,
    input  logic                 Reset,
    maze_player_ctrl_if.master   bus
);

    maze_state_e        state_q, state_d;
    logic [CELL_W-1:0]  cell_x_q, cell_x_d;
    logic [CELL_W-1:0]  cell_y_q, cell_y_d;
    logic [CELL_W-1:0]  tgt_x_q, tgt_x_d;
    logic [CELL_W-1:0]  tgt_y_q, tgt_y_d;
    logic [ADDR_W-1:0]  map_addr_q, map_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win_q, win_d;

    logic               any_dir;
    logic               in_bounds;
    logic               lookup_ok;
    logic [CELL_W-1:0]  nx, ny;
    dir_e               dir;
    logic               wall;
    logic               at_goal;

    // Target decode for a request in IDLE; edges are never wrapped.
    always_comb begin
        any_dir   = bus.up_p | bus.down_p | bus.left_p | bus.right_p;
        dir       = pick_dir(bus.up_p, bus.down_p, bus.left_p, bus.right_p);
        nx        = cell_x_q;
        ny        = cell_y_q;
        in_bounds = 1'b0;
        unique case (dir)
            DIR_UP: begin
                in_bounds = (cell_y_q != '0);
                ny        = cell_y_q - 1'b1;
            end
            DIR_DOWN: begin
                in_bounds = (cell_y_q != CELL_W'(ROWS - 1));
                ny        = cell_y_q + 1'b1;
            end
            DIR_LEFT: begin
                in_bounds = (cell_x_q != '0);
                nx        = cell_x_q - 1'b1;
            end
            DIR_RIGHT: begin
                in_bounds = (cell_x_q != CELL_W'(COLS - 1));
                nx        = cell_x_q + 1'b1;
            end
        endcase
        lookup_ok = any_dir & in_bounds;
    end

    assign wall    = bus.map_row[tgt_x_q];
    assign at_goal = (tgt_x_q == CELL_W'(GOAL_X)) && (tgt_y_q == CELL_W'(GOAL_Y));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cell_x_q   <= CELL_W'(START_X);
            cell_y_q   <= CELL_W'(START_Y);
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            map_addr_q <= '0;
            cnt_q      <= '0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cell_x_q   <= cell_x_d;
            cell_y_q   <= cell_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            map_addr_q <= map_addr_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
        end
    end

    // Next-state logic; centre_p always returns to IDLE, aborting any lookup in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!bus.centre_p && lookup_ok) state_d = S_WAIT;
            S_WAIT:  state_d = bus.centre_p ? S_IDLE : S_CHECK;
            S_CHECK: begin
                if (!bus.centre_p && !wall && at_goal) state_d = S_WIN;
                else                                   state_d = S_IDLE;
            end
            S_WIN:   if (bus.centre_p) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cell_x_d   = cell_x_q;
        cell_y_d   = cell_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        map_addr_d = map_addr_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        if (bus.centre_p) begin
            cell_x_d = CELL_W'(START_X);
            cell_y_d = CELL_W'(START_Y);
            cnt_d    = '0;
            win_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (lookup_ok) begin
                        tgt_x_d    = nx;
                        tgt_y_d    = ny;
                        map_addr_d = ADDR_W'(ny);
                    end
                end
                S_CHECK: begin
                    if (!wall) begin
                        cell_x_d = tgt_x_q;
                        cell_y_d = tgt_y_q;
                        if (cnt_q != CNT_W'(MAX_MOVES)) cnt_d = cnt_q + 1'b1;
                        if (at_goal) win_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.map_addr   = map_addr_q;
    assign bus.x_coord    = PIX_W'(cell_x_q) * PIX_W'(CELL_PX);
    assign bus.y_coord    = PIX_W'(cell_y_q) * PIX_W'(CELL_PX);
    assign bus.move_count = cnt_q;
    assign bus.win        = win_q;
    assign bus.busy       = (state_q == S_WAIT) || (state_q == S_CHECK);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed and randomized bench for maze_player_ctrl against a cell-level player model
// and a registered map ROM kept in the bench.
module tb_maze_player_ctrl;
    import maze_pkg::*;

    localparam int GX = 29;
    localparam int GY = 19;
    localparam int MAXM = 9999;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    maze_player_ctrl_if bus();

    maze_player_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [COLS-1:0] maze [ROWS];

    always @(posedge Clk) bus.map_row <= maze[bus.map_addr];

    int vectors = 0;
    int miscompares = 0;

    int m_x, m_y, m_cnt, m_addr;
    bit m_win;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".x"},     32'(bus.x_coord),    32'(m_x * CELL_PX));
        chk({tag, ".y"},     32'(bus.y_coord),    32'(m_y * CELL_PX));
        chk({tag, ".count"}, 32'(bus.move_count), 32'(m_cnt));
        chk({tag, ".win"},   32'(bus.win),        32'(m_win));
        chk({tag, ".busy"},  32'(bus.busy),       32'd0);
        chk({tag, ".addr"},  32'(bus.map_addr),   32'(m_addr));
    endtask

    task automatic model_restart();
        m_x = 0; m_y = 0; m_cnt = 0; m_win = 0;
    endtask

    task automatic clear_pulses();
        bus.up_p = 0; bus.down_p = 0; bus.left_p = 0; bus.right_p = 0; bus.centre_p = 0;
    endtask

    // Called at a negedge; drives one pulse cycle and ends at a negedge with the move settled.
    // extra: 0 none, 1 inject right_p while busy, 2 inject centre_p while busy.
    task automatic step(input bit u, input bit d, input bit l, input bit r, input bit c,
                        input int extra);
        bit go;
        int tx, ty;
        go = 0; tx = m_x; ty = m_y;
        bus.up_p = u; bus.down_p = d; bus.left_p = l; bus.right_p = r; bus.centre_p = c;
        if (c) model_restart();
        else if (!m_win && (u | d | l | r)) begin
            if (u)      ty = m_y - 1;
            else if (d) ty = m_y + 1;
            else if (l) tx = m_x - 1;
            else        tx = m_x + 1;
            go = (tx >= 0) && (tx < COLS) && (ty >= 0) && (ty < ROWS);
            if (go) m_addr = ty;
        end
        @(negedge Clk);
        clear_pulses();
        chk("busy_wait", 32'(bus.busy), 32'(go));
        chk("addr_wait", 32'(bus.map_addr), 32'(m_addr));
        if (go && extra == 1) bus.right_p = 1;
        if (go && extra == 2) bus.centre_p = 1;
        @(negedge Clk);
        clear_pulses();
        if (go && extra == 2) begin
            model_restart();
            go = 0;
        end
        chk("busy_check", 32'(bus.busy), 32'(go));
        @(negedge Clk);
        if (go && !maze[ty][tx]) begin
            m_x = tx; m_y = ty;
            if (m_cnt < MAXM) m_cnt++;
            if (tx == GX && ty == GY) m_win = 1;
        end
        chk_all("step");
    endtask

    initial begin
        Reset = 1'b1;
        clear_pulses();
        for (int i = 0; i < ROWS; i++) maze[i] = '0;
        model_restart();
        m_addr = 0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_all("reset");
        Reset = 1'b0;

        // free move right from (0,0)
        step(0, 0, 0, 1, 0, 0);
        // wall below (1,0)
        maze[1][1] = 1'b1;
        step(0, 1, 0, 0, 0, 0);
        // back to (0,0), then up+left at the corner: up wins and is out of bounds
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        // priority and drop while busy
        maze[1] = '0;
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 1);
        // restart aborts a lookup in flight
        step(0, 1, 0, 0, 0, 2);

        // walk to the goal on a free map
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < COLS - 1; i++) step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < ROWS - 1; i++) step(0, 1, 0, 0, 0, 0);
        chk("win_reached", 32'(bus.win), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);

        // random maze and random pulses
        for (int rr = 0; rr < ROWS; rr++)
            for (int cc = 0; cc < COLS; cc++)
                maze[rr][cc] = ($urandom_range(0, 3) == 0);
        for (int n = 0; n < 400; n++) begin
            int pat;
            pat = $urandom_range(0, 15);
            step(pat[0], pat[1], pat[2], pat[3], ($urandom_range(0, 24) == 0),
                 $urandom_range(0, 2));
        end

        // saturation on a free map
        for (int i = 0; i < ROWS; i++) maze[i] = '0;
        step(0, 0, 0, 0, 1, 0);
        for (int n = 0; n < 10000; n++) begin
            if (n % 2 == 0) step(0, 0, 0, 1, 0, 0);
            else            step(0, 0, 1, 0, 0, 0);
        end
        chk("saturated", 32'(bus.move_count), 32'(MAXM));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
